cdc_hs_rx: RTL and testbench

CDC_HS_RX -- requirements
Module: cdc_hs_rx

---
 rtl/cdc_hs_rx_pkg.sv | 14 +
 rtl/cdc_hs_rx_sync.sv | 23 ++
 rtl/cdc_hs_rx.sv | 123 ++++++++++++
 tb/tb_cdc_hs_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_rx_pkg.sv
// Shared types and constants for the toggle-handshake CDC receiver.
package cdc_hs_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StAck
  } state_e;

  localparam int unsigned MaskLen = 3;
  localparam int unsigned MaskW   = $clog2(MaskLen + 1);
  localparam int unsigned OvrCntW = 8;

endpackage

// File: rtl/cdc_hs_rx_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
module cdc_hs_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/cdc_hs_rx.sv
// Receive side of a toggle request/ack CDC handshake with overrun detection.
// Define CDC_HS_RX_OVR_CNT_EN to build the saturating overrun counter.
module cdc_hs_rx
  import cdc_hs_rx_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ACK_ON_ACCEPT = 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               req_tgl,
  input  logic [DATA_W-1:0]  req_data,
  output logic               ack_tgl,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               ovr_err,
  input  logic               ovr_clr,
  output logic [OvrCntW-1:0] ovr_cnt
);

  state_e             state_q, state_d;
  logic               s2, s3_q;
  logic [MaskW-1:0]   mask_q, mask_d;
  logic               ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic               req_edge, capture, accept, overrun;

  cdc_hs_rx_sync u_sync (
    .clk_i  (clk),
    .rst_ni (rstb),
    .d_i    (req_tgl),
    .q_o    (s2)
  );

  // Edges seen during the post-reset mask are absorbed since s3 still tracks s2.
  assign req_edge = (s2 != s3_q) && (mask_q == '0);
  assign mask_d   = (mask_q != '0) ? mask_q - 1'b1 : mask_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      s3_q    <= 1'b0;
      mask_q  <= MaskW'(MaskLen);
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s3_q    <= s2;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_edge) state_d = StHold;
      StHold:  if (valid_q && out_ready) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    capture = (state_q == StIdle) && req_edge;
    accept  = (state_q == StHold) && valid_q && out_ready;
    overrun = req_edge && (state_q != StIdle);

    valid_d = valid_q;
    if (capture) valid_d = 1'b1;
    if (accept)  valid_d = 1'b0;

    data_d = capture ? req_data : data_q;

    ack_d = ack_q;
    if (ACK_ON_ACCEPT != 0) begin
      if (state_q == StAck) ack_d = ~ack_q;
    end else if (capture) begin
      ack_d = ~ack_q;
    end

    // A same-cycle overrun beats the clear.
    err_d = err_q;
    if (overrun)      err_d = 1'b1;
    else if (ovr_clr) err_d = 1'b0;
  end

`ifdef CDC_HS_RX_OVR_CNT_EN
  logic [OvrCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (overrun) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (ovr_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ovr_cnt = cnt_q;
`else
  assign ovr_cnt = '0;
`endif

  assign ack_tgl   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ovr_err   = err_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Bench for cdc_hs_rx: directed scenarios plus random traffic against an event-level model,
// with one instance per ack mode sharing the same stimulus.
module tb_cdc_hs_rx;

`ifdef CDC_HS_RX_OVR_CNT_EN
  localparam int CntOne = 1;
  localparam int CntSat = 255;
`else
  localparam int CntOne = 0;
  localparam int CntSat = 0;
`endif

  logic        clk = 1'b0;
  logic        rstb, req_tgl, out_ready, ovr_clr;
  logic [31:0] req_data;
  logic        ack1, valid1, err1, ack0, valid0, err0;
  logic [31:0] data1, data0;
  logic [7:0]  cnt1, cnt0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdc_hs_rx #(.DATA_W(32), .ACK_ON_ACCEPT(1)) u_dut1 (
    .clk(clk), .rstb(rstb), .req_tgl(req_tgl), .req_data(req_data), .ack_tgl(ack1),
    .out_valid(valid1), .out_data(data1), .out_ready(out_ready), .ovr_err(err1),
    .ovr_clr(ovr_clr), .ovr_cnt(cnt1)
  );

  cdc_hs_rx #(.DATA_W(32), .ACK_ON_ACCEPT(0)) u_dut0 (
    .clk(clk), .rstb(rstb), .req_tgl(req_tgl), .req_data(req_data), .ack_tgl(ack0),
    .out_valid(valid0), .out_data(data0), .out_ready(out_ready), .ovr_err(err0),
    .ovr_clr(ovr_clr), .ovr_cnt(cnt0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges numbered from reset release; a level change first sampled at edge k is
  // seen as a request at edge k+2, ignored if that is within the first 3 edges.
  int          edge_n;
  logic        last_req;
  int          det_q[$];
  bit          m_valid, m_err;
  logic [31:0] m_data;
  int          acc_edge, m_cnt;
  logic        m_ack1, m_ack0;

  task automatic model_step();
    bit det, ovr;
    if (!rstb) begin
      edge_n = 0; last_req = 1'b0; det_q.delete();
      m_valid = 0; m_err = 0; m_data = '0; acc_edge = -10; m_cnt = 0;
      m_ack1 = 1'b0; m_ack0 = 1'b0;
      return;
    end
    edge_n++;
    det = 0;
    if (det_q.size() > 0 && det_q[0] == edge_n) begin
      void'(det_q.pop_front());
      det = (edge_n > 3);
    end
    if (req_tgl != last_req) begin
      det_q.push_back(edge_n + 2);
      last_req = req_tgl;
    end
    ovr = det && (m_valid || edge_n == acc_edge + 1);
    if (edge_n == acc_edge + 1) m_ack1 = ~m_ack1;
    if (m_valid && out_ready) begin
      m_valid  = 0;
      acc_edge = edge_n;
    end else if (det && !ovr) begin
      m_valid = 1;
      m_data  = req_data;
      m_ack0  = ~m_ack0;
    end
    if (ovr) begin
      m_err = 1;
`ifdef CDC_HS_RX_OVR_CNT_EN
      if (m_cnt < 255) m_cnt++;
`endif
    end else if (ovr_clr) begin
      m_err = 0;
      m_cnt = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("valid1", valid1, m_valid);
      chk("valid0", valid0, m_valid);
      chk("data1", data1, m_data);
      chk("data0", data0, m_data);
      chk("ack1", ack1, m_ack1);
      chk("ack0", ack0, m_ack0);
      chk("err1", err1, m_err);
      chk("err0", err0, m_err);
      chk("cnt1", cnt1, m_cnt);
      chk("cnt0", cnt0, m_cnt);
    end
  end

  task automatic edge2();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rstb = 1'b0; req_tgl = 1'b0; req_data = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid1, 0);
    chk("rst_ack", ack1, 0);
    chk("rst_err", err1, 0);
    chk("rst_data", data1, 0);
    rstb = 1'b1;
    repeat (6) @(negedge clk);

    // Basic transfer
    req_data = 32'hA5A5_0001; req_tgl = 1'b1; out_ready = 1'b1;
    edge2(); chk("basic_v_k", valid1, 0);
    edge2(); chk("basic_v_k1", valid1, 0);
    edge2(); chk("basic_v_k2", valid1, 1);
    chk("basic_data", data1, 32'hA5A5_0001);
    chk("basic_ack0_capture", ack0, 1);
    chk("basic_ack1_early", ack1, 0);
    edge2(); chk("basic_v_drop", valid1, 0);
    edge2(); chk("basic_ack1", ack1, 1);

    // Backpressure
    @(negedge clk); out_ready = 1'b0; req_data = 32'h1234_5678; req_tgl = 1'b0;
    repeat (3) edge2();
    chk("bp_valid", valid1, 1);
    chk("bp_ack0", ack0, 0);
    for (int i = 0; i < 10; i++) begin
      edge2();
      chk("bp_hold_valid", valid1, 1);
      chk("bp_hold_data", data1, 32'h1234_5678);
      chk("bp_hold_ack1", ack1, 1);
    end
    @(negedge clk); out_ready = 1'b1;
    edge2(); chk("bp_accept_valid", valid1, 0); chk("bp_accept_ack1", ack1, 1);
    edge2(); chk("bp_ack1", ack1, 0);

    // Overrun
    @(negedge clk); out_ready = 1'b0; req_data = 32'hDEAD_BEEF; req_tgl = 1'b1;
    repeat (3) edge2();
    chk("ovr_valid", valid1, 1);
    @(negedge clk); req_data = 32'h0BAD_F00D; req_tgl = 1'b0;
    repeat (3) edge2();
    chk("ovr_err", err1, 1);
    chk("ovr_cnt", cnt1, CntOne);
    chk("ovr_data", data1, 32'hDEAD_BEEF);
    @(negedge clk); ovr_clr = 1'b1;
    edge2(); chk("ovr_clr_err", err1, 0); chk("ovr_clr_cnt", cnt1, 0);
    @(negedge clk); ovr_clr = 1'b0; out_ready = 1'b1;
    repeat (3) edge2();
    chk("ovr_drain_valid", valid1, 0);
    chk("ovr_drain_ack1", ack1, 1);

    // Saturation
    @(negedge clk); out_ready = 1'b0; req_data = 32'h5A5A_0300; req_tgl = 1'b1;
    repeat (3) edge2();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); req_tgl = ~req_tgl; req_data = $urandom;
    end
    repeat (4) edge2();
    chk("sat_cnt", cnt1, CntSat);
    chk("sat_err", err1, 1);
    chk("sat_data", data1, 32'h5A5A_0300);
    @(negedge clk); ovr_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset exit with req_tgl already high
    rstb = 1'b0; req_tgl = 1'b1;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge2(); chk("mask_no_valid", valid1, 0);
    end

    // Reset while holding a word
    @(negedge clk); out_ready = 1'b0; req_data = 32'hC0DE_0007; req_tgl = 1'b0;
    repeat (3) edge2();
    chk("hold_valid", valid1, 1);
    chk("hold_ack0", ack0, 1);
    @(negedge clk); rstb = 1'b0;
    #1;
    chk("rst_hold_valid1", valid1, 0);
    chk("rst_hold_valid0", valid0, 0);
    chk("rst_hold_ack0", ack0, 0);
    chk("rst_hold_ack1", ack1, 0);
    @(negedge clk); rstb = 1'b1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        req_tgl  = ~req_tgl;
        req_data = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      ovr_clr   = ($urandom_range(0, 15) == 0);
      rstb      = ($urandom_range(0, 999) != 0);
    end

    @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
